// File: rtl/clk_gen_ds_multi.sv
// clk_gen_ds_multi: multi-channel programmable clock divider with shadowed, glitch-free config updates.
// Optional per-channel period-complete strobes on tick_o when CLK_GEN_DS_TICK_EN is defined.
module clk_gen_ds_multi #(
    parameter int channels_p = 4,
    parameter int width_p    = 8,
    localparam int ch_w_lp   = (channels_p > 1) ? $clog2(channels_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cfg_v_i,
    output logic                  cfg_ready_o,
    input  logic [ch_w_lp-1:0]    cfg_ch_i,
    input  logic [width_p-1:0]    cfg_div_i,
    input  logic                  cfg_en_i,
    input  logic                  sync_i,
    output logic [channels_p-1:0] clk_o,
    output logic [channels_p-1:0] tick_o
);
    logic [width_p-1:0]    div_q [channels_p];
    logic [width_p-1:0]    div_d [channels_p];
    logic [width_p-1:0]    cnt_q [channels_p];
    logic [width_p-1:0]    cnt_d [channels_p];
    logic [width_p-1:0]    sdiv_q [channels_p];
    logic [width_p-1:0]    sdiv_d [channels_p];
    logic [channels_p-1:0] en_q, en_d, out_q, out_d, sen_q, sen_d, pend_q, pend_d;
    logic [channels_p-1:0] wr, wrap, fin;

    // Out-of-range channel indices never match, so they read as ready and are dropped.
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int c = 0; c < channels_p; c++)
            if (cfg_ch_i == ch_w_lp'(c)) cfg_ready_o = ~pend_q[c];
    end

    always_comb begin
        for (int c = 0; c < channels_p; c++) begin
            wr[c]     = cfg_v_i & cfg_ready_o & (cfg_ch_i == ch_w_lp'(c));
            wrap[c]   = cnt_q[c] == div_q[c];
            fin[c]    = en_q[c] & wrap[c] & out_q[c];
            div_d[c]  = div_q[c];
            en_d[c]   = en_q[c];
            cnt_d[c]  = cnt_q[c];
            out_d[c]  = out_q[c];
            sdiv_d[c] = sdiv_q[c];
            sen_d[c]  = sen_q[c];
            pend_d[c] = pend_q[c];
            if (sync_i) begin
                div_d[c]  = wr[c] ? cfg_div_i : pend_q[c] ? sdiv_q[c] : div_q[c];
                en_d[c]   = wr[c] ? cfg_en_i : pend_q[c] ? sen_q[c] : en_q[c];
                cnt_d[c]  = '0;
                out_d[c]  = 1'b0;
                pend_d[c] = 1'b0;
            end else if (wr[c] & ~en_q[c]) begin
                div_d[c] = cfg_div_i;
                en_d[c]  = cfg_en_i;
                cnt_d[c] = '0;
                out_d[c] = 1'b0;
            end else if (fin[c] & pend_q[c]) begin
                div_d[c]  = sdiv_q[c];
                en_d[c]   = sen_q[c];
                cnt_d[c]  = '0;
                out_d[c]  = 1'b0;
                pend_d[c] = 1'b0;
            end else begin
                if (wr[c]) begin
                    sdiv_d[c] = cfg_div_i;
                    sen_d[c]  = cfg_en_i;
                    pend_d[c] = 1'b1;
                end
                if (en_q[c]) begin
                    cnt_d[c] = wrap[c] ? '0 : cnt_q[c] + 1'b1;
                    out_d[c] = out_q[c] ^ wrap[c];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < channels_p; c++) begin
            div_q[c]  <= reset_i ? '0 : div_d[c];
            cnt_q[c]  <= reset_i ? '0 : cnt_d[c];
            sdiv_q[c] <= reset_i ? '0 : sdiv_d[c];
        end
        en_q   <= reset_i ? '0 : en_d;
        out_q  <= reset_i ? '0 : out_d;
        sen_q  <= reset_i ? '0 : sen_d;
        pend_q <= reset_i ? '0 : pend_d;
    end

    assign clk_o = out_q;

`ifdef CLK_GEN_DS_TICK_EN
    logic [channels_p-1:0] tick_q;
    always_ff @(posedge clk_i) tick_q <= (reset_i | sync_i) ? '0 : fin;
    assign tick_o = tick_q;
`else
    assign tick_o = '0;
`endif
endmodule

// File: tb/tb_clk_gen_ds_multi.sv
// tb_clk_gen_ds_multi: directed stimulus, phase-arithmetic reference model checked every cycle.
module tb_clk_gen_ds_multi;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          cfg_v_i = 1'b0;
    logic          cfg_ready_o;
    logic [CW-1:0] cfg_ch_i = '0;
    logic [W-1:0]  cfg_div_i = '0;
    logic          cfg_en_i = 1'b0;
    logic          sync_i = 1'b0;
    logic [CH-1:0] clk_o;
    logic [CH-1:0] tick_o;

    int checks = 0;
    int errors = 0;

    clk_gen_ds_multi dut (
        .clk_i(clk), .reset_i(reset_i), .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o),
        .cfg_ch_i(cfg_ch_i), .cfg_div_i(cfg_div_i), .cfg_en_i(cfg_en_i), .sync_i(sync_i),
        .clk_o(clk_o), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    // Model: each channel is a square wave of period 2(d+1) starting low at cycle m_start.
    int            cyc = 0;
    bit            mvalid = 1'b0;
    int            m_d [CH];
    int            m_sd [CH];
    int            m_start [CH];
    bit            m_en [CH];
    bit            m_sen [CH];
    bit            m_pend [CH];
    bit [CH-1:0]   tick_exp = '0;

    function automatic bit exp_out(int c);
        return m_en[c] && ((cyc - m_start[c]) % (2 * (m_d[c] + 1))) >= m_d[c] + 1;
    endfunction

    function automatic bit exp_ready();
        return !m_pend[cfg_ch_i];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit [CH-1:0] f;
        bit rdy, w;
        rdy = exp_ready();
        for (int c = 0; c < CH; c++)
            f[c] = m_en[c] && ((cyc - m_start[c]) % (2 * (m_d[c] + 1))) == 2 * m_d[c] + 1;
        if (reset_i) begin
            for (int c = 0; c < CH; c++) begin
                m_d[c] = 0; m_sd[c] = 0; m_start[c] = cyc + 1;
                m_en[c] = 0; m_sen[c] = 0; m_pend[c] = 0;
            end
            tick_exp = '0;
            mvalid = 1'b1;
        end else begin
            for (int c = 0; c < CH; c++) begin
                w = cfg_v_i && rdy && (cfg_ch_i == c);
                if (sync_i) begin
                    if (w) begin m_d[c] = cfg_div_i; m_en[c] = cfg_en_i; end
                    else if (m_pend[c]) begin m_d[c] = m_sd[c]; m_en[c] = m_sen[c]; end
                    m_start[c] = cyc + 1;
                    m_pend[c] = 0;
                end else if (w && !m_en[c]) begin
                    m_d[c] = cfg_div_i; m_en[c] = cfg_en_i; m_start[c] = cyc + 1;
                end else if (w) begin
                    m_sd[c] = cfg_div_i; m_sen[c] = cfg_en_i; m_pend[c] = 1;
                end else if (f[c] && m_pend[c]) begin
                    m_d[c] = m_sd[c]; m_en[c] = m_sen[c]; m_start[c] = cyc + 1; m_pend[c] = 0;
                end
            end
            tick_exp = sync_i ? '0 : f;
        end
        cyc++;
    end

    always @(negedge clk) if (mvalid) begin
        logic [CH-1:0] e;
        for (int c = 0; c < CH; c++) e[c] = exp_out(c);
        chk("model_clk_o", clk_o, e);
        chk("model_cfg_ready_o", cfg_ready_o, exp_ready());
`ifdef CLK_GEN_DS_TICK_EN
        chk("model_tick_o", tick_o, tick_exp);
`else
        chk("model_tick_o", tick_o, 0);
`endif
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(int ch, int d, bit en);
        int n = 0;
        cfg_v_i = 1'b1; cfg_ch_i = CW'(ch); cfg_div_i = W'(d); cfg_en_i = en;
        #1;
        while (!cfg_ready_o && n < 2000) begin @(posedge clk); #2; n++; end
        chk("wr_accept_bound", n < 2000, 1);
        @(posedge clk); #1;
        cfg_v_i = 1'b0;
    endtask

    task automatic wait_until(int c, bit v);
        int n = 0;
        while (clk_o[c] !== v && n < 2000) begin step(1); n++; end
        chk("wait_bound", n < 2000, 1);
    endtask

    task automatic measure(int c, int ehi, int elo);
        int n = 0, hi = 0, lo = 0;
        while (clk_o[c] !== 1'b0 && n < 2000) begin step(1); n++; end
        while (clk_o[c] !== 1'b1 && n < 2000) begin step(1); n++; end
        while (clk_o[c] === 1'b1 && n < 2000) begin step(1); hi++; n++; end
        while (clk_o[c] === 1'b0 && n < 2000) begin step(1); lo++; n++; end
        chk($sformatf("high_len_ch%0d", c), hi, ehi);
        chk($sformatf("low_len_ch%0d", c), lo, elo);
    endtask

    initial begin
        step(3);
        reset_i = 1'b0;
        #1;
        chk("reset_clk_o", clk_o, 0);
        chk("reset_tick_o", tick_o, 0);
        chk("reset_ready", cfg_ready_o, 1);

        // ch0 d=0: rises two cycles after acceptance, period 2
        wr(0, 0, 1);
        chk("ch0_T1", clk_o[0], 0);
        step(1);
        chk("ch0_T2", clk_o, 4'b0001);
        step(1);
        chk("ch0_T3", clk_o[0], 0);

        // ch1 d=3 and ch2 d=255
        wr(1, 3, 1);
        wr(2, 255, 1);
        step(2);
        chk("ch1_T4", clk_o[1], 0);
        step(1);
        chk("ch1_T5", clk_o[1], 1);
        step(3);
        chk("ch1_T8", clk_o[1], 1);
        step(1);
        chk("ch1_T9", clk_o[1], 0);
        measure(1, 4, 4);
        measure(2, 256, 256);

        // shadowed update mid high phase, then a stalled second write
        wait_until(1, 1);
        step(1);
        wr(1, 1, 1);
        cfg_ch_i = 2'd1;
        #1;
        chk("pend_ready_low", cfg_ready_o, 0);
        wr(1, 1, 1);
        measure(1, 2, 2);
`ifdef CLK_GEN_DS_TICK_EN
        begin
            int t = 0;
            for (int i = 0; i < 8; i++) begin t += tick_o[1]; step(1); end
            chk("tick_count_ch1", t, 2);
        end
`endif

        // disable a running channel: finishes high phase, then direct writes
        wait_until(1, 1);
        wr(1, 0, 0);
        step(20);
        chk("ch1_stopped", clk_o[1], 0);
        cfg_ch_i = 2'd1;
        #1;
        chk("ch1_ready_after_stop", cfg_ready_o, 1);
        wr(1, 2, 1);
        cfg_ch_i = 2'd1;
        #1;
        chk("ch1_direct_no_pend", cfg_ready_o, 1);
        step(2);
        chk("ch1_d2_T3", clk_o[1], 0);
        step(1);
        chk("ch1_d2_T4", clk_o[1], 1);

        // sync alignment: ch0 d=1, ch1 d=2
        wr(0, 1, 1);
        step(7);
        sync_i = 1'b1;
        step(1);
        sync_i = 1'b0;
        chk("sync_T1", clk_o, 4'b0000);
        step(1);
        chk("sync_T2", clk_o[1:0], 2'b00);
        step(1);
        chk("sync_T3", clk_o[1:0], 2'b01);
        step(1);
        chk("sync_T4", clk_o[1:0], 2'b11);

        // write accepted in the same cycle as sync is applied immediately
        step(3);
        sync_i = 1'b1; cfg_v_i = 1'b1; cfg_ch_i = 2'd2; cfg_div_i = 8'd1; cfg_en_i = 1'b1;
        step(1);
        sync_i = 1'b0; cfg_v_i = 1'b0;
        chk("syncwr_T1", clk_o, 4'b0000);
        step(2);
        chk("syncwr_T3", clk_o, 4'b0101);

        // reset while ch0 has a pending write
        wr(0, 3, 1);
        cfg_ch_i = 2'd0;
        #1;
        chk("pend_before_reset", cfg_ready_o, 0);
        reset_i = 1'b1;
        step(1);
        reset_i = 1'b0;
        chk("midreset_clk_o", clk_o, 0);
        #1;
        chk("midreset_ready", cfg_ready_o, 1);
        chk("midreset_tick", tick_o, 0);
        wr(0, 0, 1);
        step(1);
        chk("post_reset_ch0", clk_o, 4'b0001);
        step(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
